// File: rtl/c4_pkg.sv
// Shared definitions for the connect-four move pipeline: cell codes,
// move outcome codes, line-window count and the drop sequencer states.
package c4_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    localparam logic [1:0] STATUS_PLACED   = 2'b00;
    localparam logic [1:0] STATUS_WIN      = 2'b01;
    localparam logic [1:0] STATUS_DRAW     = 2'b10;
    localparam logic [1:0] STATUS_REJECTED = 2'b11;

    // down, row_1..4, right_up_1..4, left_down_1..4
    localparam int NUM_WINDOWS = 13;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        CHECK,
        DONE
    } state_t;

    // Hands the turn to the other player.
    function automatic logic [1:0] other_player(input logic [1:0] player);
        return (player == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/line_window_mask.sv
// Validity mask for the 13 four-cell windows through cell (row, col).
// A window is valid only if every one of its cells lies on the board;
// the checker wraps its indices, so invalid windows must be ignored.
// Bit order: [0] down, [4:1] row_4..row_1, [8:5] right_up_4..right_up_1,
// [12:9] left_down_4..left_down_1.
module line_window_mask
    import c4_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int ROW_BITS = 3,
    parameter int COL_BITS = 3
) (
    input  logic [ROW_BITS-1:0]    row,
    input  logic [COL_BITS-1:0]    col,
    output logic [NUM_WINDOWS-1:0] mask
);

    // Window k places the piece at a different offset along the line, so
    // the bounds shift with k; left_down runs up-left to down-right.
    always_comb begin
        int r;
        int c;
        r = int'(row);
        c = int'(col);
        mask = '0;
        mask[0] = (r >= 3);
        for (int k = 1; k <= 4; k++) begin
            mask[k]     = (c >= 4 - k) && (c <= COLS - k);
            mask[4 + k] = (r >= 4 - k) && (c >= 4 - k) &&
                          (r <= ROWS - k) && (c <= COLS - k);
            mask[8 + k] = (r >= k - 1) && (r <= ROWS + k - 5) &&
                          (c >= 4 - k) && (c <= COLS - k);
        end
    end

endmodule

// File: rtl/drop_controller.sv
// Connect-four move sequencer: owns the board, scans a column for the
// lowest empty row, places the current player's piece, then judges the
// move from the external direction checker's masked line results.
module drop_controller
    import c4_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int ROW_BITS = 3,
    parameter int COL_BITS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     new_game,
    input  logic                     drop_valid,
    input  logic [COL_BITS-1:0]      drop_col,
    output logic                     drop_ready,
    output logic [ROWS*COLS*2-1:0]   board_vec,
    output logic [ROW_BITS-1:0]      current_row,
    output logic [COL_BITS-1:0]      current_col,
    output logic [1:0]               current_player,
    input  logic                     result_down,
    input  logic                     result_row_1,
    input  logic                     result_row_2,
    input  logic                     result_row_3,
    input  logic                     result_row_4,
    input  logic                     result_diag_right_up_1,
    input  logic                     result_diag_right_up_2,
    input  logic                     result_diag_right_up_3,
    input  logic                     result_diag_right_up_4,
    input  logic                     result_diag_left_down_1,
    input  logic                     result_diag_left_down_2,
    input  logic                     result_diag_left_down_3,
    input  logic                     result_diag_left_down_4,
    output logic                     move_done,
    output logic [1:0]               move_status,
    output logic                     game_over,
    output logic [1:0]               winner
);

    localparam int MOVE_BITS = $clog2(ROWS * COLS + 1);
    localparam int IDX_BITS  = $clog2(ROWS * COLS * 2);

    state_t                  state;
    logic [ROW_BITS-1:0]     scan_row;
    logic [COL_BITS-1:0]     scan_col;
    logic [MOVE_BITS-1:0]    move_count;
    logic [IDX_BITS-1:0]     scan_idx;
    logic [NUM_WINDOWS-1:0]  line_results;
    logic [NUM_WINDOWS-1:0]  window_mask;
    logic                    is_win;

    assign scan_idx = IDX_BITS'((int'(scan_row) * COLS + int'(scan_col)) * 2);

    assign line_results = {result_diag_left_down_4, result_diag_left_down_3,
                           result_diag_left_down_2, result_diag_left_down_1,
                           result_diag_right_up_4,  result_diag_right_up_3,
                           result_diag_right_up_2,  result_diag_right_up_1,
                           result_row_4, result_row_3, result_row_2, result_row_1,
                           result_down};

    line_window_mask #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS)
    ) u_mask (
        .row  (current_row),
        .col  (current_col),
        .mask (window_mask)
    );

    assign is_win     = |(line_results & window_mask);
    assign drop_ready = (state == IDLE) && !game_over;

    // Move sequencer: board, turn bookkeeping and registered outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            board_vec      <= '0;
            scan_row       <= '0;
            scan_col       <= '0;
            current_row    <= '0;
            current_col    <= '0;
            current_player <= P1;
            move_count     <= '0;
            move_done      <= 1'b0;
            move_status    <= STATUS_PLACED;
            game_over      <= 1'b0;
            winner         <= EMPTY;
        end else if (new_game) begin
            state          <= IDLE;
            board_vec      <= '0;
            scan_row       <= '0;
            scan_col       <= '0;
            current_row    <= '0;
            current_col    <= '0;
            current_player <= P1;
            move_count     <= '0;
            move_done      <= 1'b0;
            move_status    <= STATUS_PLACED;
            game_over      <= 1'b0;
            winner         <= EMPTY;
        end else begin
            move_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (drop_valid && !game_over) begin
                        if (int'(drop_col) >= COLS) begin
                            move_status <= STATUS_REJECTED;
                            move_done   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            scan_col <= drop_col;
                            scan_row <= '0;
                            state    <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (board_vec[scan_idx +: 2] == EMPTY) begin
                        board_vec[scan_idx +: 2] <= current_player;
                        current_row <= scan_row;
                        current_col <= scan_col;
                        move_count  <= move_count + 1'b1;
                        state       <= CHECK;
                    end else if (scan_row == ROW_BITS'(ROWS - 1)) begin
                        move_status <= STATUS_REJECTED;
                        move_done   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        scan_row <= scan_row + 1'b1;
                    end
                end
                CHECK: begin
                    if (is_win) begin
                        move_status <= STATUS_WIN;
                        winner      <= current_player;
                        game_over   <= 1'b1;
                    end else if (move_count == MOVE_BITS'(ROWS * COLS)) begin
                        move_status <= STATUS_DRAW;
                        winner      <= EMPTY;
                        game_over   <= 1'b1;
                    end else begin
                        move_status    <= STATUS_PLACED;
                        current_player <= other_player(current_player);
                    end
                    move_done <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drop_controller.sv
// Bench for drop_controller: a wrapping direction-checker model drives the
// result inputs, and a board-level game model predicts every outcome.
module tb_drop_controller;

    localparam int ROWS     = 8;
    localparam int COLS     = 8;
    localparam int ROW_BITS = 3;
    localparam int COL_BITS = 3;

    logic                    clk;
    logic                    rst_n;
    logic                    new_game;
    logic                    drop_valid;
    logic [COL_BITS-1:0]     drop_col;
    logic                    drop_ready;
    logic [ROWS*COLS*2-1:0]  board_vec;
    logic [ROW_BITS-1:0]     current_row;
    logic [COL_BITS-1:0]     current_col;
    logic [1:0]              current_player;
    logic [12:0]             env_res;
    logic                    move_done;
    logic [1:0]              move_status;
    logic                    game_over;
    logic [1:0]              winner;

    int checks;
    int errors;

    int model_board [ROWS][COLS];
    int model_player;
    int model_count;
    int model_over;
    int model_winner;
    int model_row;
    int model_col;

    drop_controller #(
        .ROWS(ROWS), .COLS(COLS), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .new_game                (new_game),
        .drop_valid              (drop_valid),
        .drop_col                (drop_col),
        .drop_ready              (drop_ready),
        .board_vec               (board_vec),
        .current_row             (current_row),
        .current_col             (current_col),
        .current_player          (current_player),
        .result_down             (env_res[0]),
        .result_row_1            (env_res[1]),
        .result_row_2            (env_res[2]),
        .result_row_3            (env_res[3]),
        .result_row_4            (env_res[4]),
        .result_diag_right_up_1  (env_res[5]),
        .result_diag_right_up_2  (env_res[6]),
        .result_diag_right_up_3  (env_res[7]),
        .result_diag_right_up_4  (env_res[8]),
        .result_diag_left_down_1 (env_res[9]),
        .result_diag_left_down_2 (env_res[10]),
        .result_diag_left_down_3 (env_res[11]),
        .result_diag_left_down_4 (env_res[12]),
        .move_done               (move_done),
        .move_status             (move_status),
        .game_over               (game_over),
        .winner                  (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell test with the checker's wrapping index arithmetic.
    function automatic bit wrap_match(input logic [ROWS*COLS*2-1:0] vec,
                                      input int r, input int c, input logic [1:0] p);
        int rr;
        int cc;
        rr = r & (ROWS - 1);
        cc = c & (COLS - 1);
        return vec[(rr * COLS + cc) * 2 +: 2] == p;
    endfunction

    // Direction checker as it exists downstream: no bounds knowledge at all.
    function automatic logic [12:0] env_checker(input logic [ROWS*COLS*2-1:0] vec,
                                                input int r, input int c,
                                                input logic [1:0] p);
        logic [12:0] res;
        bit a;
        bit b;
        bit d;
        res = '0;
        res[0] = wrap_match(vec, r, c, p) && wrap_match(vec, r - 1, c, p) &&
                 wrap_match(vec, r - 2, c, p) && wrap_match(vec, r - 3, c, p);
        for (int k = 1; k <= 4; k++) begin
            a = 1'b1;
            b = 1'b1;
            d = 1'b1;
            for (int j = -(4 - k); j <= k - 1; j++) begin
                a = a & wrap_match(vec, r, c + j, p);
                b = b & wrap_match(vec, r + j, c + j, p);
            end
            for (int j = -(k - 1); j <= 4 - k; j++) begin
                d = d & wrap_match(vec, r + j, c - j, p);
            end
            res[k]     = a;
            res[4 + k] = b;
            res[8 + k] = d;
        end
        return res;
    endfunction

    always_comb begin
        env_res = env_checker(board_vec, int'(current_row), int'(current_col), current_player);
    end

    // True four-in-a-line through (r,c) on the model board, bounded to the board.
    function automatic bit ref_win(input int r, input int c, input int p);
        int dr;
        int dc;
        int n;
        int rr;
        int cc;
        for (int d = 0; d < 4; d++) begin
            case (d)
                0: begin dr = 0; dc = 1; end
                1: begin dr = 1; dc = 0; end
                2: begin dr = 1; dc = 1; end
                default: begin dr = 1; dc = -1; end
            endcase
            n = 1;
            rr = r + dr; cc = c + dc;
            while (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS && model_board[rr][cc] == p) begin
                n++; rr += dr; cc += dc;
            end
            rr = r - dr; cc = c - dc;
            while (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS && model_board[rr][cc] == p) begin
                n++; rr -= dr; cc -= dc;
            end
            if (n >= 4) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [ROWS*COLS*2-1:0] model_vec();
        logic [ROWS*COLS*2-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r * COLS + c) * 2 +: 2] = 2'(model_board[r][c]);
        return v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model_board[r][c] = 0;
        model_player = 1;
        model_count  = 0;
        model_over   = 0;
        model_winner = 0;
        model_row    = 0;
        model_col    = 0;
    endtask

    task automatic apply_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
    endtask

    // One complete drop: predict with the model, drive, then judge the outcome.
    task automatic do_drop(input int col, input bit noise, input string tag);
        int row;
        int exp_lat;
        int k;
        logic [1:0] exp_status;
        row = -1;
        for (int r = 0; r < ROWS; r++)
            if (row < 0 && model_board[r][col] == 0) row = r;
        if (row < 0) begin
            exp_status = 2'b11;
            exp_lat    = ROWS;
        end else begin
            model_board[row][col] = model_player;
            model_count++;
            model_row = row;
            model_col = col;
            exp_lat   = row + 2;
            if (ref_win(row, col, model_player)) begin
                exp_status   = 2'b01;
                model_over   = 1;
                model_winner = model_player;
            end else if (model_count == ROWS * COLS) begin
                exp_status   = 2'b10;
                model_over   = 1;
                model_winner = 0;
            end else begin
                exp_status   = 2'b00;
                model_player = 3 - model_player;
            end
        end

        @(negedge clk);
        checks++;
        if (drop_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s ready_before: got %b want 1", tag, drop_ready);
        end
        drop_valid = 1'b1;
        drop_col   = COL_BITS'(col);
        @(negedge clk);
        drop_valid = 1'b0;
        k = 0;
        while (move_done !== 1'b1 && k < 40) begin
            if (noise) begin
                drop_valid = 1'($urandom_range(0, 1));
                drop_col   = COL_BITS'($urandom_range(0, COLS - 1));
            end
            @(negedge clk);
            k++;
        end
        drop_valid = 1'b0;

        checks++;
        if (k != exp_lat) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d want %0d", tag, k, exp_lat);
        end
        checks++;
        if (move_status !== exp_status) begin
            errors++;
            $display("[TB] FAIL %s status: got %b want %b", tag, move_status, exp_status);
        end
        checks++;
        if (winner !== 2'(model_winner) || game_over !== 1'(model_over)) begin
            errors++;
            $display("[TB] FAIL %s result: got winner=%b over=%b want winner=%0d over=%0d",
                     tag, winner, game_over, model_winner, model_over);
        end
        checks++;
        if (board_vec !== model_vec()) begin
            errors++;
            $display("[TB] FAIL %s board: got %h want %h", tag, board_vec, model_vec());
        end
        checks++;
        if (current_player !== 2'(model_player) || current_row !== ROW_BITS'(model_row) ||
            current_col !== COL_BITS'(model_col)) begin
            errors++;
            $display("[TB] FAIL %s position: got p=%b r=%0d c=%0d want p=%0d r=%0d c=%0d",
                     tag, current_player, current_row, current_col, model_player, model_row, model_col);
        end

        @(negedge clk);
        checks++;
        if (move_done !== 1'b0 || drop_ready !== !model_over[0] || move_status !== exp_status) begin
            errors++;
            $display("[TB] FAIL %s after_done: got done=%b ready=%b status=%b want 0 %0d %b",
                     tag, move_done, drop_ready, move_status, !model_over[0], exp_status);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        new_game   = 1'b0;
        drop_valid = 1'b0;
        drop_col   = '0;
        model_clear();
        repeat (2) @(negedge clk);
        checks++;
        if (board_vec !== '0 || current_player !== 2'b01 || current_row !== '0 ||
            current_col !== '0 || move_done !== 1'b0 || move_status !== 2'b00 ||
            game_over !== 1'b0 || winner !== 2'b00 || drop_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset: got p=%b r=%0d c=%0d done=%b st=%b over=%b win=%b ready=%b",
                     current_player, current_row, current_col, move_done, move_status,
                     game_over, winner, drop_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (drop_ready !== 1'b1 || board_vec !== '0) begin
            errors++;
            $display("[TB] FAIL reset_release: got ready=%b want 1", drop_ready);
        end
    endtask

    task automatic test_first_drop();
        do_drop(3, 1'b0, "first_drop");
    endtask

    task automatic test_full_column();
        apply_new_game();
        for (int i = 0; i < ROWS; i++) do_drop(0, 1'b0, "fill_col0");
        do_drop(0, 1'b0, "full_col0");
    endtask

    task automatic test_drop_when_over(input string tag);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        drop_valid = 1'b1;
        drop_col   = COL_BITS'($urandom_range(0, COLS - 1));
        repeat (12) begin
            @(negedge clk);
            if (move_done === 1'b1) seen = 1'b1;
        end
        drop_valid = 1'b0;
        checks++;
        if (seen || drop_ready !== 1'b0 || game_over !== 1'b1 || board_vec !== model_vec()) begin
            errors++;
            $display("[TB] FAIL %s ignored: got done_seen=%0d ready=%b over=%b want 0 0 1",
                     tag, seen, drop_ready, game_over);
        end
    endtask

    task automatic test_horizontal_win();
        apply_new_game();
        do_drop(0, 1'b0, "hwin");
        do_drop(7, 1'b0, "hwin");
        do_drop(1, 1'b0, "hwin");
        do_drop(7, 1'b0, "hwin");
        do_drop(2, 1'b0, "hwin");
        do_drop(7, 1'b0, "hwin");
        do_drop(3, 1'b0, "hwin_final");
        test_drop_when_over("hwin");
    endtask

    // Each player owns cols 5..7 of one row and then plays col 0 of that row,
    // which completes only the wrapped row window.
    task automatic test_wrap_mask();
        int seq [8];
        seq = '{5, 5, 6, 6, 7, 7, 0, 0};
        apply_new_game();
        foreach (seq[i]) do_drop(seq[i], 1'b0, "wrap_mask");
    endtask

    task automatic test_draw();
        int p1c [4];
        int p2c [4];
        int n1;
        int n2;
        apply_new_game();
        for (int r = 0; r < ROWS; r++) begin
            n1 = 0;
            n2 = 0;
            for (int c = 0; c < COLS; c++) begin
                if ((((c >> 1) + r) & 1) == 0) begin p1c[n1] = c; n1++; end
                else begin p2c[n2] = c; n2++; end
            end
            for (int i = 0; i < 4; i++) begin
                do_drop(p1c[i], 1'b0, "draw");
                do_drop(p2c[i], 1'b0, "draw");
            end
        end
        test_drop_when_over("draw");
    endtask

    task automatic test_new_game_abort();
        bit seen;
        apply_new_game();
        for (int i = 0; i < 3; i++) do_drop(2, 1'b0, "abort_setup");
        @(negedge clk);
        drop_valid = 1'b1;
        drop_col   = 3'd2;
        @(negedge clk);
        drop_valid = 1'b1;
        drop_col   = 3'd4;
        new_game   = 1'b1;
        @(negedge clk);
        new_game   = 1'b0;
        drop_valid = 1'b0;
        model_clear();
        checks++;
        if (drop_ready !== 1'b1 || board_vec !== '0 || current_player !== 2'b01 ||
            game_over !== 1'b0 || move_status !== 2'b00) begin
            errors++;
            $display("[TB] FAIL abort_state: got ready=%b p=%b over=%b st=%b board=%h",
                     drop_ready, current_player, game_over, move_status, board_vec);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (move_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || board_vec !== '0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got done_seen=%0d want 0", seen);
        end
        do_drop(4, 1'b0, "after_abort");
    endtask

    task automatic test_random_games();
        for (int g = 0; g < 3; g++) begin
            apply_new_game();
            for (int m = 0; m < 70 && model_over == 0; m++)
                do_drop(int'($urandom_range(0, COLS - 1)), 1'b1, "random");
            if (model_over != 0) test_drop_when_over("random");
        end
    endtask

    task automatic test_async_reset();
        apply_new_game();
        do_drop(5, 1'b0, "pre_async");
        do_drop(5, 1'b0, "pre_async");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (board_vec !== '0 || current_player !== 2'b01 || game_over !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got p=%b over=%b board=%h", current_player,
                     game_over, board_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        do_drop(6, 1'b0, "post_async");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_first_drop();
        test_full_column();
        test_horizontal_win();
        test_wrap_mask();
        test_draw();
        test_new_game_abort();
        test_random_games();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
